// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer: alignment check, req/ack bus cycle with timeout,
// byte-enable/lane-replicated writes, and sign/zero load extension for writeback.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, DONE = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]  size_q, size_d;
  logic [1:0]  off_q, off_d;
  logic        signed_q, signed_d;
  logic [31:0] rdata_q, rdata_d;
  logic        adel_q, adel_d;
  logic        ades_q, ades_d;
  logic        berr_q, berr_d;

  logic        is_byte, is_half, misaligned, timeout_hit;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc, load_ext;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign is_byte     = (req_size == 2'b00);
  assign is_half     = (req_size == 2'b01);
  assign misaligned  = (is_half & req_addr[0]) |
                       (~is_byte & ~is_half & (req_addr[1:0] != 2'b00));
  assign timeout_hit = ((cnt_q + 8'd1) == 8'(TIMEOUT));

  always_comb begin
    if (is_byte) begin
      be_calc    = 4'b0001 << req_addr[1:0];
      wdata_calc = {4{req_wdata[7:0]}};
    end else if (is_half) begin
      be_calc    = req_addr[1] ? 4'b1100 : 4'b0011;
      wdata_calc = {2{req_wdata[15:0]}};
    end else begin
      be_calc    = 4'b1111;
      wdata_calc = req_wdata;
    end
  end

  // Extension works on the live bus word so it can be captured in the ack cycle.
  always_comb begin
    byte_lane = mem_rdata[{off_q, 3'b000} +: 8];
    half_lane = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      2'b00:   load_ext = {{24{signed_q & byte_lane[7]}}, byte_lane};
      2'b01:   load_ext = {{16{signed_q & half_lane[15]}}, half_lane};
      default: load_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = misaligned ? DONE : BUS;
      BUS:     if (mem_ack || timeout_hit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    size_d      = size_q;
    off_d       = off_q;
    signed_d    = signed_q;
    rdata_d     = rdata_q;
    adel_d      = adel_q;
    ades_d      = ades_q;
    berr_d      = berr_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (misaligned) begin
            adel_d  = ~req_we;
            ades_d  = req_we;
            rdata_d = 32'd0;
          end else begin
            cnt_d       = 8'd0;
            mem_req_d   = 1'b1;
            mem_we_d    = req_we;
            mem_addr_d  = {req_addr[31:2], 2'b00};
            mem_be_d    = be_calc;
            mem_wdata_d = wdata_calc;
            size_d      = req_size;
            off_d       = req_addr[1:0];
            signed_d    = req_signed;
          end
        end
      end
      BUS: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          rdata_d   = mem_we_q ? 32'd0 : load_ext;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (timeout_hit) begin
            mem_req_d = 1'b0;
            berr_d    = 1'b1;
            rdata_d   = 32'd0;
          end
        end
      end
      default: begin
        rdata_d = 32'd0;
        adel_d  = 1'b0;
        ades_d  = 1'b0;
        berr_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= 8'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_be_q    <= 4'd0;
      mem_wdata_q <= 32'd0;
      size_q      <= 2'd0;
      off_q       <= 2'd0;
      signed_q    <= 1'b0;
      rdata_q     <= 32'd0;
      adel_q      <= 1'b0;
      ades_q      <= 1'b0;
      berr_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      size_q      <= size_d;
      off_q       <= off_d;
      signed_q    <= signed_d;
      rdata_q     <= rdata_d;
      adel_q      <= adel_d;
      ades_q      <= ades_d;
      berr_q      <= berr_d;
    end
  end

  assign done      = (state_q == DONE);
  assign stall     = req_valid & ~done;
  assign rdata     = rdata_q;
  assign exc_adel  = adel_q;
  assign exc_ades  = ades_q;
  assign bus_err   = berr_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed cases plus randomized accesses against an
// arithmetic reference model of alignment, byte enables, lane replication and extension.
module tb_mem_access_ctrl;
  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        stall, done, exc_adel, exc_ades, bus_err, mem_req, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_rdata;

  mem_access_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .stall(stall), .done(done), .rdata(rdata),
    .exc_adel(exc_adel), .exc_ades(exc_ades), .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit misal(input logic [1:0] size, input logic [31:0] addr);
    return (addr % nbytes(size)) != 0;
  endfunction

  function automatic logic [31:0] exp_be(input logic [1:0] size, input logic [31:0] addr);
    int off = addr % 4;
    if (nbytes(size) == 1) return 32'(1 << off);
    if (nbytes(size) == 2) return 32'(3 << (off - off % 2));
    return 32'd15;
  endfunction

  function automatic logic [31:0] exp_wd(input logic [1:0] size, input logic [31:0] wd);
    if (nbytes(size) == 1) return (wd % 256) * 32'h0101_0101;
    if (nbytes(size) == 2) return (wd % 65536) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] ext_load(input logic [1:0] size, input bit sgn,
                                           input logic [31:0] addr, input logic [31:0] word);
    int off = addr % 4;
    logic [31:0] v;
    if (nbytes(size) == 1) begin
      v = (word >> (8 * off)) % 256;
      if (sgn && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (nbytes(size) == 2) begin
      v = (word >> (8 * (off - off % 2))) % 65536;
      if (sgn && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = word;
    end
    return v;
  endfunction

  // Issues one request at a negedge with state IDLE; ack_delay >= TIMEOUT means never ack.
  task automatic do_access(input logic we, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input int ack_delay, input logic [31:0] rd, input string tag);
    bit mis, berr, got;
    int lat, n, cyc, stall_cnt;
    logic [31:0] exp_rd;
    mis    = misal(size, addr);
    berr   = !mis && (ack_delay >= TIMEOUT);
    lat    = mis ? 1 : (berr ? TIMEOUT + 1 : ack_delay + 2);
    exp_rd = (mis || we || berr) ? 32'd0 : ext_load(size, sgn, addr, rd);
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wd; mem_ack = 1'b0;
    n = 0; cyc = 0; got = 0; stall_cnt = 0;
    #1;
    if (stall) stall_cnt++;
    while (!got && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        got = 1;
      end else begin
        n++;
        if (stall) stall_cnt++;
        chk({tag, "_req"}, {31'd0, mem_req}, 32'd1);
        chk({tag, "_we"}, {31'd0, mem_we}, {31'd0, we});
        chk({tag, "_addr"}, mem_addr, addr - addr % 4);
        chk({tag, "_be"}, {28'd0, mem_be}, exp_be(size, addr));
        if (we) chk({tag, "_wdata"}, mem_wdata, exp_wd(size, wd));
        mem_ack   = (n == ack_delay + 1);
        mem_rdata = mem_ack ? rd : $urandom();
      end
    end
    chk({tag, "_got_done"}, {31'd0, got}, 32'd1);
    chk({tag, "_latency"}, cyc, lat);
    chk({tag, "_bus_cycles"}, n, lat - 1);
    chk({tag, "_stall_cycles"}, stall_cnt, lat);
    chk({tag, "_rdata"}, rdata, exp_rd);
    chk({tag, "_adel"}, {31'd0, exc_adel}, {31'd0, mis && !we});
    chk({tag, "_ades"}, {31'd0, exc_ades}, {31'd0, mis && we});
    chk({tag, "_bus_err"}, {31'd0, bus_err}, {31'd0, berr});
    chk({tag, "_req_at_done"}, {31'd0, mem_req}, 32'd0);
    chk({tag, "_stall_at_done"}, {31'd0, stall}, 32'd0);
    last_rdata = rdata;
    req_valid = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    chk({tag, "_flags_clr"}, {rdata[28:0], exc_adel, exc_ades, bus_err}, 32'd0);
  endtask

  initial begin
    int n;
    logic [1:0] sz;
    logic [31:0] a;
    int dly;

    @(negedge clk);
    @(negedge clk);
    chk("rst_outs", {stall, done, exc_adel, exc_ades, bus_err, mem_req, mem_we}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_bus", mem_addr | mem_wdata | {28'd0, mem_be}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    do_access(1'b0, 2'b10, 1'b0, 32'h0000_1004, 32'd0, 0, 32'hDEAD_BEEF, "lw");
    chk("lw_lit", last_rdata, 32'hDEAD_BEEF);
    do_access(1'b0, 2'b00, 1'b1, 32'h0000_1007, 32'd0, 0, 32'h80FF_0000, "lb");
    chk("lb_lit", last_rdata, 32'hFFFF_FF80);
    do_access(1'b0, 2'b00, 1'b0, 32'h0000_1007, 32'd0, 0, 32'h80FF_0000, "lbu");
    chk("lbu_lit", last_rdata, 32'h0000_0080);
    do_access(1'b0, 2'b01, 1'b1, 32'h0000_1006, 32'd0, 0, 32'h80FF_0000, "lh");
    chk("lh_lit", last_rdata, 32'hFFFF_80FF);
    do_access(1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h1234_ABCD, 3, 32'hFFFF_FFFF, "sh");
    do_access(1'b0, 2'b10, 1'b0, 32'h0000_3001, 32'd0, 0, 32'd0, "lw_mis");
    do_access(1'b1, 2'b10, 1'b0, 32'h0000_3002, 32'h5555_5555, 0, 32'd0, "sw_mis");
    do_access(1'b0, 2'b10, 1'b0, 32'h0000_4000, 32'd0, 99, 32'h1111_2222, "tmo");
    do_access(1'b0, 2'b10, 1'b0, 32'h0000_4000, 32'd0, TIMEOUT - 1, 32'h1111_2222, "ack_last");

    // Stray acks while idle must not start or complete anything.
    mem_ack = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_ack", {30'd0, done, mem_req}, 32'd0);
    mem_ack = 1'b0;

    // Reset landing in the second bus cycle aborts without a done pulse.
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h0000_5000;
    n = 0;
    while (n < 2 && n < 10) begin
      @(negedge clk);
      if (mem_req) n++; else n = 10;
    end
    chk("rst_mid_bus_reached", n, 2);
    reset = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mid_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_nodone", {31'd0, done}, 32'd0);
    do_access(1'b0, 2'b10, 1'b0, 32'h0000_5000, 32'd0, 1, 32'hCAFE_F00D, "lw_after_rst");

    for (int i = 0; i < 30; i++) begin
      sz  = 2'($urandom_range(0, 3));
      a   = $urandom();
      if ($urandom_range(0, 3) != 0) a = a - a % nbytes(sz) + 32'(nbytes(sz) == 1 ? a % 4 : 0);
      dly = ($urandom_range(0, 7) == 0) ? TIMEOUT + 2 : $urandom_range(0, 4);
      do_access(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom(),
                dly, $urandom(), "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
